wb_queue: RTL and testbench

- Write-back queue that sits directly upstream of the register file's single write port.
- Accepts up to two register writes per cycle: a load result from the memory stage and an ALU result from the execute stage.
- Buffers them in order and drains exactly one per cycle into the register file's write_en/write_addr/write_data.
- Exposes two lookup ports so decode can forward values that are still queued and not yet written.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_lookup.sv | 34 +++
 rtl/wb_queue.sv | 92 +++++++++
 tb/tb_wb_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizing for the write-back queue ahead of the register file write port.
package wb_pkg;
  localparam int N_W     = 32;
  localparam int R_W     = 5;
  localparam int DEPTH_D = 4;
  localparam int PTR_W   = $clog2(DEPTH_D);

  typedef struct packed {
    logic [R_W-1:0] addr;
    logic [N_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the queued entries for one decode forwarding port.
module wb_lookup
  import wb_pkg::*;
#(
  parameter int n     = N_W,
  parameter int r     = R_W,
  parameter int DEPTH = DEPTH_D,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [PW:0]      count,
  input  logic [r-1:0]     lookup_addr,
  output logic             hit,
  output logic [n-1:0]     fwd_data
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && valid[idx] && (entries[idx].addr == lookup_addr) &&
          (lookup_addr != '0)) begin
        hit      = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// Write-back queue: takes up to two writes per cycle, drains one per cycle in order.
module wb_queue
  import wb_pkg::*;
#(
  parameter int n     = N_W,
  parameter int r     = R_W,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [r-1:0]             ld_addr,
  input  logic [n-1:0]             ld_data,
  input  logic                     alu_valid,
  input  logic [r-1:0]             alu_addr,
  input  logic [n-1:0]             alu_data,
  output logic                     in_ready,
  output logic                     write_en,
  output logic [r-1:0]             write_addr,
  output logic [n-1:0]             write_data,
  input  logic [r-1:0]             lookup_addr1,
  input  logic [r-1:0]             lookup_addr2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [n-1:0]             fwd_data1,
  output logic [n-1:0]             fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count_q, free, enq_n;
  logic             ld_ok, alu_ok, ld_keep, alu_keep, deq;

  // Free slots ignore the same-cycle dequeue; the load is older, so it gets a slot first.
  always_comb begin
    ld_ok    = ld_valid && (ld_addr != '0);
    alu_ok   = alu_valid && (alu_addr != '0);
    free     = DEPTH_C - count_q;
    ld_keep  = ld_ok && (free != '0);
    alu_keep = alu_ok && (free > {PW'(0), ld_keep});
    enq_n    = {PW'(0), ld_keep} + {PW'(0), alu_keep};
    deq      = (count_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      valid    <= '0;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (ld_keep) begin
        entries[tail] <= '{addr: ld_addr, data: ld_data};
        valid[tail]   <= 1'b1;
      end
      if (alu_keep) begin
        entries[tail + PW'(ld_keep)] <= '{addr: alu_addr, data: alu_data};
        valid[tail + PW'(ld_keep)]   <= 1'b1;
      end
      tail    <= tail + enq_n[PW-1:0];
      count_q <= count_q + enq_n - {PW'(0), deq};
      if ((ld_ok && !ld_keep) || (alu_ok && !alu_keep)) overflow <= 1'b1;
    end
  end

  assign count      = count_q;
  assign in_ready   = (count_q <= DEPTH_C - (PW+1)'(2));
  assign write_en   = deq;
  assign write_addr = valid[head] ? entries[head].addr : '0;
  assign write_data = valid[head] ? entries[head].data : '0;

  wb_lookup #(.n(n), .r(r), .DEPTH(DEPTH), .PW(PW)) u_lookup1 (
    .entries(entries), .valid(valid), .head(head), .count(count_q),
    .lookup_addr(lookup_addr1), .hit(hit1), .fwd_data(fwd_data1)
  );

  wb_lookup #(.n(n), .r(r), .DEPTH(DEPTH), .PW(PW)) u_lookup2 (
    .entries(entries), .valid(valid), .head(head), .count(count_q),
    .lookup_addr(lookup_addr2), .hit(hit2), .fwd_data(fwd_data2)
  );
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with an in-order scoreboard of expected register file writes.
module tb_wb_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0, alu_valid = 1'b0;
  logic [4:0]  ld_addr = '0, alu_addr = '0, lookup_addr1 = '0, lookup_addr2 = '0;
  logic [31:0] ld_data = '0, alu_data = '0;
  logic        in_ready, write_en, hit1, hit2, overflow;
  logic [4:0]  write_addr;
  logic [31:0] write_data, fwd_data1, fwd_data2;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf [32];
  int          total = 0;
  int          bad = 0;

  wb_queue dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .in_ready(in_ready), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
    .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, count, 0);
  endtask

  // Register file model: captures whatever the queue presents on each write edge.
  always @(posedge clk) if (write_en) rf[write_addr] <= write_data;

  // Every drain cycle must match the oldest outstanding expected write.
  always @(negedge clk) begin
    exp_t e;
    if (rst && write_en) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("wr_addr", write_addr, e.addr);
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // reset values
    #2;
    chk("rst_count", count, 0);
    chk("rst_we", write_en, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_hit1", hit1, 0);
    chk("rst_fwd2", fwd_data2, 0);
    #10 rst = 1'b1;
    step();

    // single write
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; push(5, 32'hDEADBEEF);
    step(); idle_inputs();
    chk("single_count1", count, 1);
    chk("single_we", write_en, 1);
    step();
    chk("single_count0", count, 0);
    chk("single_rf5", rf[5], 32'hDEADBEEF);

    // dual write to the same register
    ld_valid = 1; ld_addr = 7; ld_data = 32'h11; push(7, 32'h11);
    alu_valid = 1; alu_addr = 7; alu_data = 32'h22; push(7, 32'h22);
    step(); idle_inputs();
    lookup_addr1 = 7;
    #1;
    chk("dual_count2", count, 2);
    chk("dual_hit1", hit1, 1);
    chk("dual_fwd1", fwd_data1, 32'h22);
    step();
    chk("dual_count1", count, 1);
    chk("dual_hit1b", hit1, 1);
    chk("dual_fwd1b", fwd_data1, 32'h22);
    step();
    chk("dual_count0", count, 0);
    chk("dual_hit1_gone", hit1, 0);
    chk("dual_fwd1_gone", fwd_data1, 0);
    chk("dual_rf7", rf[7], 32'h22);

    // x0 discard
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF; lookup_addr2 = 0;
    step(); idle_inputs();
    chk("x0_count", count, 0);
    chk("x0_we", write_en, 0);
    chk("x0_hit2", hit2, 0);

    // back-pressure and overflow
    ld_valid = 1; ld_addr = 1; ld_data = 32'hA1; push(1, 32'hA1);
    alu_valid = 1; alu_addr = 2; alu_data = 32'hA2; push(2, 32'hA2);
    step();
    chk("full_count2", count, 2);
    chk("full_ready2", in_ready, 1);
    ld_addr = 3; ld_data = 32'hA3; push(3, 32'hA3);
    alu_addr = 4; alu_data = 32'hA4; push(4, 32'hA4);
    step();
    chk("full_count3", count, 3);
    chk("full_ready3", in_ready, 0);
    chk("full_ovf0", overflow, 0);
    lookup_addr2 = 4;
    ld_addr = 5; ld_data = 32'hA5; push(5, 32'hA5);
    alu_addr = 6; alu_data = 32'hA6;
    step(); idle_inputs();
    chk("ovf_count", count, 3);
    chk("ovf_set", overflow, 1);
    chk("ovf_hit2", hit2, 1);
    chk("ovf_fwd2", fwd_data2, 32'hA4);
    wait_empty("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    chk("ovf_rf5", rf[5], 32'hA5);
    chk("ovf_rf6", rf[6], 32'h0);

    // streaming with wrap-around
    for (int i = 1; i <= 10; i++) begin
      alu_valid = 1; alu_addr = 5'(i); alu_data = 32'(i * 3); push(5'(i), 32'(i * 3));
      step();
      chk("stream_we", write_en, 1);
      chk("stream_ready", in_ready, 1);
    end
    idle_inputs();
    step();
    chk("stream_count0", count, 0);
    chk("stream_rf1", rf[1], 3);
    chk("stream_rf10", rf[10], 30);

    // reset in the middle of traffic
    ld_valid = 1; ld_addr = 8; ld_data = 32'h80; push(8, 32'h80);
    alu_valid = 1; alu_addr = 9; alu_data = 32'h90; push(9, 32'h90);
    step();
    ld_valid = 0; alu_addr = 10; alu_data = 32'hA0; push(10, 32'hA0);
    step(); idle_inputs();
    lookup_addr1 = 10;
    #1;
    chk("mid_count", count, 2);
    chk("mid_hit1", hit1, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", write_en, 0);
    chk("mid_rst_hit1", hit1, 0);
    chk("mid_rst_ovf", overflow, 0);
    sb.delete();
    #2 rst = 1'b1;
    step();
    step();
    chk("post_rst_count", count, 0);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
